// File: rtl/image_rom_arbiter.sv
// image_rom_arbiter: shares one ImageRom port between the raster
// reader (strict priority) and a valid/ready processing engine.
module image_rom_arbiter #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int ADDR_W     = 19,
    parameter int ROM_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [7:0]        disp_data,
    input  logic              proc_req_valid,
    output logic              proc_req_ready,
    input  logic [ADDR_W-1:0] proc_addr,
    output logic              proc_rsp_valid,
    input  logic              proc_rsp_ready,
    output logic [7:0]        proc_rsp_data,
    output logic              oob_err,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_q
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W:0] PIX =
        (ADDR_W+1)'(WIDTH * HEIGHT);
    localparam logic [CW:0] DEPTH_C =
        (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_DISP = 2'd1,
        G_PROC = 2'd2
    } grant_t;

    typedef struct packed {
        grant_t g;
        logic   oob;
    } tag_t;

    grant_t            grant;
    tag_t              tag_in;
    tag_t              tag_q [ROM_LAT];
    tag_t              tag_out;
    logic [ADDR_W-1:0] addr_q;
    logic              oob_hit;
    logic [CW-1:0]     inflight;
    logic [CW:0]       used;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          rsp_valid_q;
    logic          push;
    logic          pop;

    assign oob_hit = {1'b0, proc_addr} >= PIX;
    assign tag_out = tag_q[ROM_LAT-1];

    // Count processing reads still travelling through the ROM.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LAT; i++) begin
            if (tag_q[i].g == G_PROC) begin
                inflight = inflight + CW'(1);
            end
        end
    end

    // Credit check: every accepted read has a guaranteed FIFO slot.
    always_comb begin
        used = {1'b0, inflight} + {1'b0, count};
        proc_req_ready = reset && !disp_req &&
                         (used < DEPTH_C);
    end

    // Grant and ROM address mux; idle cycles hold the last address.
    always_comb begin
        grant    = G_NONE;
        rom_addr = addr_q;
        if (disp_req) begin
            grant    = G_DISP;
            rom_addr = disp_addr;
        end else if (proc_req_valid && proc_req_ready) begin
            grant    = G_PROC;
            rom_addr = proc_addr;
        end
        tag_in.g   = grant;
        tag_in.oob = (grant == G_PROC) && oob_hit;
    end

    // Tag shift register aligned with ROM read latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                tag_q[i] <= '0;
            end
            addr_q <= '0;
        end else begin
            tag_q[0] <= tag_in;
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            addr_q <= rom_addr;
        end
    end

    // Display output register; data holds between display beats.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_valid <= 1'b0;
            disp_data  <= '0;
        end else begin
            disp_valid <= (tag_out.g == G_DISP);
            if (tag_out.g == G_DISP) begin
                disp_data <= rom_q;
            end
        end
    end

    // Sticky out-of-range flag, set on acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oob_err <= 1'b0;
        end else if (tag_in.oob) begin
            oob_err <= 1'b1;
        end
    end

    assign push = (tag_out.g == G_PROC);
    assign pop  = rsp_valid_q && proc_rsp_ready;

    // Next occupancy; push with pop keeps the count.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Response FIFO storage, pointers and registered valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= tag_out.oob ? 8'h00 : rom_q;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count       <= count_next;
            rsp_valid_q <= (count_next != '0);
        end
    end

    assign proc_rsp_valid = rsp_valid_q;
    assign proc_rsp_data  = mem[rd_ptr];

endmodule

// File: tb/tb_image_rom_arbiter.sv
// tb_image_rom_arbiter: scoreboard bench for the ROM arbiter
// with a one-cycle registered ROM model.
module tb_image_rom_arbiter;

    localparam int AW  = 19;
    localparam int PIX = 640 * 480;
    localparam int LAT = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_valid;
    logic [7:0]    disp_data;
    logic          proc_req_valid;
    logic          proc_req_ready;
    logic [AW-1:0] proc_addr;
    logic          proc_rsp_valid;
    logic          proc_rsp_ready;
    logic [7:0]    proc_rsp_data;
    logic          oob_err;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_q = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] dq [$];
    int         dt [$];
    logic [7:0] pq [$];

    image_rom_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .disp_req       (disp_req),
        .disp_addr      (disp_addr),
        .disp_valid     (disp_valid),
        .disp_data      (disp_data),
        .proc_req_valid (proc_req_valid),
        .proc_req_ready (proc_req_ready),
        .proc_addr      (proc_addr),
        .proc_rsp_valid (proc_rsp_valid),
        .proc_rsp_ready (proc_rsp_ready),
        .proc_rsp_data  (proc_rsp_data),
        .oob_err        (oob_err),
        .rom_addr       (rom_addr),
        .rom_q          (rom_q)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_val(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // ROM model: address sampled at the edge, data one cycle later.
    always @(posedge clk) rom_q <= rom_val(rom_addr);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: pop/compare outputs, then push new expectations.
    always @(negedge clk) begin
        if (!reset) begin
            dq.delete();
            dt.delete();
            pq.delete();
        end else begin
            if (disp_valid) begin
                chk("disp_pending", 32'(dq.size() != 0), 1);
                if (dq.size() != 0) begin
                    chk("disp_data", disp_data, dq.pop_front());
                    chk("disp_lat", cyc, dt.pop_front());
                end
            end
            if (proc_rsp_valid && proc_rsp_ready) begin
                chk("proc_pending", 32'(pq.size() != 0), 1);
                if (pq.size() != 0) begin
                    chk("proc_data", proc_rsp_data, pq.pop_front());
                end
            end
            if (disp_req) begin
                dq.push_back(rom_val(disp_addr));
                dt.push_back(cyc + LAT + 1);
            end
            if (proc_req_valid && proc_req_ready) begin
                if (int'(proc_addr) >= PIX) pq.push_back(8'h00);
                else pq.push_back(rom_val(proc_addr));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        disp_req       = 1'b0;
        proc_req_valid = 1'b0;
        repeat (n) next_cycle();
    endtask

    int acc;
    int acc2;
    int nxt;

    initial begin
        reset          = 1'b0;
        disp_req       = 1'b0;
        disp_addr      = '0;
        proc_req_valid = 1'b1;
        proc_addr      = '0;
        proc_rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_disp_valid", disp_valid, 0);
        chk("rst_disp_data", disp_data, 0);
        chk("rst_rsp_valid", proc_rsp_valid, 0);
        chk("rst_rsp_data", proc_rsp_data, 0);
        chk("rst_oob", oob_err, 0);
        chk("rst_ready", proc_req_ready, 0);
        next_cycle();
        reset          = 1'b1;
        proc_req_valid = 1'b0;
        next_cycle();

        // 1: display priority
        for (int i = 0; i < 8; i++) begin
            disp_req       = 1'b1;
            disp_addr      = AW'(i);
            proc_req_valid = 1'b1;
            proc_addr      = AW'(50);
            @(negedge clk);
            chk("t1_ready", proc_req_ready, 0);
            next_cycle();
        end
        idle(4);
        chk("t1_drain", dq.size(), 0);
        chk("t1_noproc", proc_rsp_valid, 0);

        // 2: blanking service
        proc_rsp_ready = 1'b1;
        for (int a = 100; a < 103; a++) begin
            proc_req_valid = 1'b1;
            proc_addr      = AW'(a);
            @(negedge clk);
            chk("t2_ready", proc_req_ready, 1);
            next_cycle();
        end
        idle(6);
        chk("t2_drain", pq.size(), 0);

        // 3: backpressure
        proc_rsp_ready = 1'b0;
        acc = 0;
        nxt = 200;
        repeat (10) begin
            proc_req_valid = 1'b1;
            proc_addr      = AW'(nxt);
            @(negedge clk);
            if (proc_req_ready) begin
                acc++;
                nxt++;
            end
            next_cycle();
        end
        chk("t3_accepts", acc, 4);
        proc_addr = AW'(nxt);
        @(negedge clk);
        chk("t3_ready_low", proc_req_ready, 0);
        chk("t3_rsp_valid", proc_rsp_valid, 1);
        next_cycle();
        proc_rsp_ready = 1'b1;
        next_cycle();
        proc_rsp_ready = 1'b0;
        acc2 = 0;
        repeat (5) begin
            proc_addr = AW'(nxt);
            @(negedge clk);
            if (proc_req_ready) begin
                acc2++;
                nxt++;
            end
            next_cycle();
        end
        chk("t3_one_more", acc2, 1);
        proc_rsp_ready = 1'b1;
        idle(8);
        chk("t3_drain", pq.size(), 0);

        // 4: out-of-range address
        chk("t4_pre", oob_err, 0);
        proc_req_valid = 1'b1;
        proc_addr      = AW'(PIX);
        @(negedge clk);
        chk("t4_ready", proc_req_ready, 1);
        next_cycle();
        proc_addr = AW'(10);
        @(negedge clk);
        chk("t4_oob_set", oob_err, 1);
        next_cycle();
        proc_addr = AW'(11);
        next_cycle();
        idle(5);
        chk("t4_oob_sticky", oob_err, 1);
        chk("t4_drain", pq.size(), 0);

        // 5: interleave
        nxt = 400;
        for (int i = 0; i < 10; i++) begin
            disp_req       = (i % 2) == 0;
            disp_addr      = AW'(300 + i);
            proc_req_valid = 1'b1;
            proc_addr      = AW'(nxt);
            @(negedge clk);
            chk("t5_ready", proc_req_ready, !disp_req);
            if (proc_req_ready) nxt++;
            next_cycle();
        end
        idle(6);
        chk("t5_disp_drain", dq.size(), 0);
        chk("t5_proc_drain", pq.size(), 0);

        // 6: reset mid-flight
        proc_rsp_ready = 1'b0;
        for (int a = 500; a < 503; a++) begin
            proc_req_valid = 1'b1;
            proc_addr      = AW'(a);
            @(negedge clk);
            chk("t6_ready", proc_req_ready, 1);
            next_cycle();
        end
        proc_req_valid = 1'b0;
        #2;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t6_disp_valid", disp_valid, 0);
        chk("t6_disp_data", disp_data, 0);
        chk("t6_rsp_valid", proc_rsp_valid, 0);
        chk("t6_rsp_data", proc_rsp_data, 0);
        chk("t6_oob", oob_err, 0);
        chk("t6_ready", proc_req_ready, 0);
        next_cycle();
        reset          = 1'b1;
        proc_rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_no_stale", proc_rsp_valid, 0);
            next_cycle();
        end
        proc_req_valid = 1'b1;
        proc_addr      = AW'(600);
        next_cycle();
        idle(6);
        chk("t6_new_drain", pq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 n_checks, n_fail);
        $finish;
    end

endmodule
